// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with a 2-bit saturating counter per
// entry. It gives a zero-latency taken/target guess for the fetch PC and
// learns from branches resolved in execute.
// Optional build macro: BP_GSHARE_EN. When defined, the entry index is the
// PC index XORed with a global history register. The port list is the same
// in both builds.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = XLEN - IDX_W - 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_if,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [31:0]     mispredict_cnt
);

  // Entry storage. It stays in flops because every entry must clear on reset
  // and the lookup is combinational.
  logic            valid_reg  [ENTRIES];
  logic [TAG_W-1:0] tag_reg   [ENTRIES];
  logic [XLEN-1:0] target_reg [ENTRIES];
  logic [1:0]      ctr_reg    [ENTRIES];
  logic [31:0]     mispredict_reg;

  logic [IDX_W-1:0] look_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] look_tag;
  logic [TAG_W-1:0] upd_tag;

  // PC bits [1:0] never take part in the lookup.
  logic unused_bits;
  assign unused_bits = ^{pc_if[1:0], upd_pc[1:0]};

  assign look_tag = pc_if[XLEN-1:IDX_W+2];
  assign upd_tag  = upd_pc[XLEN-1:IDX_W+2];

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_reg;

  // Shift each resolved outcome into the global history. The update uses
  // the history value from before the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ghr_reg <= '0;
    else if (upd_valid)
      ghr_reg <= {ghr_reg[IDX_W-2:0], upd_taken};
  end

  assign look_idx = pc_if[IDX_W+1:2] ^ ghr_reg;
  assign upd_idx  = upd_pc[IDX_W+1:2] ^ ghr_reg;
`else
  assign look_idx = pc_if[IDX_W+1:2];
  assign upd_idx  = upd_pc[IDX_W+1:2];
`endif

  // Lookup path. The write lands only at the clock edge, so a lookup of the
  // entry being updated in the same cycle returns the old contents.
  assign pred_hit    = valid_reg[look_idx] && (tag_reg[look_idx] == look_tag);
  assign pred_taken  = pred_hit && ctr_reg[look_idx][1];
  assign pred_target = pred_hit ? target_reg[look_idx] : '0;

  logic       upd_hit;
  logic [1:0] upd_ctr;
  logic       upd_pred;
  logic       write_en;
  logic [1:0] ctr_next;

  assign upd_hit  = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
  assign upd_ctr  = ctr_reg[upd_idx];
  assign upd_pred = upd_hit && upd_ctr[1];

  // An entry is touched on any hit, or on a taken miss (allocation).
  assign write_en = upd_valid && (upd_hit || upd_taken);

  // Compute the next counter value. A hit saturates up or down; an
  // allocation starts at weak-taken.
  always_comb begin
    ctr_next = 2'b10;
    if (upd_hit) begin
      ctr_next = upd_ctr;
      if (upd_taken && (upd_ctr != 2'b11))
        ctr_next = upd_ctr + 2'd1;
      else if (!upd_taken && (upd_ctr != 2'b00))
        ctr_next = upd_ctr - 2'd1;
    end
  end

  // Write the indexed entry. On a hit the tag rewrite is a no-op, and the
  // target changes only for taken outcomes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i]  <= 1'b0;
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
        ctr_reg[i]    <= 2'b01;
      end
    end else if (write_en) begin
      valid_reg[upd_idx] <= 1'b1;
      tag_reg[upd_idx]   <= upd_tag;
      ctr_reg[upd_idx]   <= ctr_next;
      if (upd_taken)
        target_reg[upd_idx] <= upd_target;
    end
  end

  // Count resolutions that disagree with the stored prediction. The count
  // holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mispredict_reg <= '0;
    else if (upd_valid && (upd_pred != upd_taken) && (mispredict_reg != '1))
      mispredict_reg <= mispredict_reg + 32'd1;
  end

  assign mispredict_cnt = mispredict_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor. A behavioural model of the predictor
// tables is checked against the DUT on every clock cycle outside reset.
// Directed steps carry hand-computed literal expectations. A randomized
// phase follows.
module tb_branch_predictor;
  localparam int ENT = 64;
  localparam int IW  = 6;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.XLEN(32), .ENTRIES(ENT)) dut (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .mispredict_cnt(mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a table of entries with the counter kept as an
  // integer from 0 to 3.
  bit          m_valid [ENT];
  logic [31:0] m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_ctr   [ENT];
  longint      m_cnt;
  int          m_ghr;

  function automatic int midx(logic [31:0] pc);
    int base;
    base = int'(pc[31:2]) % ENT;
`ifdef BP_GSHARE_EN
    return base ^ m_ghr;
`else
    return base;
`endif
  endfunction

  function automatic logic [31:0] mtag(logic [31:0] pc);
    return pc >> (IW + 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENT; i++) begin
        m_valid[i] = 1'b0;
        m_tag[i] = 0;
        m_tgt[i] = 0;
        m_ctr[i] = 1;
      end
      m_cnt = 0;
      m_ghr = 0;
    end else if (upd_valid) begin
      int  i;
      bit  hit;
      bit  pred;
      i = midx(upd_pc);
      hit = m_valid[i] && (m_tag[i] == mtag(upd_pc));
      pred = hit && (m_ctr[i] >= 2);
      if (pred != upd_taken && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (hit) begin
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i] = mtag(upd_pc);
        m_tgt[i] = upd_target;
        m_ctr[i] = 2;
      end
      m_ghr = ((m_ghr << 1) | int'(upd_taken)) & (ENT - 1);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: the lookup outputs and the counter against the model,
  // once per cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      int          i;
      bit          hit;
      logic [31:0] tgt;
      i = midx(pc_if);
      hit = m_valid[i] && (m_tag[i] == mtag(pc_if));
      tgt = hit ? m_tgt[i] : 32'h0;
      check("model_hit", 64'(pred_hit), 64'(hit));
      check("model_taken", 64'(pred_taken), 64'(hit && (m_ctr[i] >= 2)));
      check("model_target", 64'(pred_target), 64'(tgt));
      check("model_mispredict", 64'(mispredict_cnt), 64'(m_cnt));
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    upd_valid = v;
    upd_pc = pc;
    upd_taken = tk;
    upd_target = tg;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return {22'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    logic [4:0] hyst;
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    pc_if = 32'h100;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hit", 64'(pred_hit), 64'd0);
    check("reset_taken", 64'(pred_taken), 64'd0);
    check("reset_target", 64'(pred_target), 64'd0);
    check("reset_cnt", 64'(mispredict_cnt), 64'd0);
    rst_n = 1'b1;
    next_cycle();

`ifndef BP_GSHARE_EN
    // Allocate 0x100. The lookup in the same cycle still misses.
    drive(1'b1, 32'h100, 1'b1, 32'h80);
    @(negedge clk);
    check("alloc_same_cycle_hit", 64'(pred_hit), 64'd0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check("alloc_hit", 64'(pred_hit), 64'd1);
    check("alloc_taken", 64'(pred_taken), 64'd1);
    check("alloc_target", 64'(pred_target), 64'h80);
    check("alloc_cnt", 64'(mispredict_cnt), 64'd1);

    // Hysteresis: NT,NT,T,NT,NT takes the counter 01,00,01,00,00.
    hyst = 5'b00100;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      drive(1'b1, 32'h100, hyst[k], 32'h80);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      check("hyst_hit", 64'(pred_hit), 64'd1);
      check("hyst_taken", 64'(pred_taken), 64'd0);
    end
    check("hyst_cnt", 64'(mispredict_cnt), 64'd3);
    // From strong-NT, two taken updates are needed before taken is predicted.
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      drive(1'b1, 32'h100, 1'b1, 32'h80);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      check("recover_taken", 64'(pred_taken), 64'(k));
    end
    check("recover_cnt", 64'(mispredict_cnt), 64'd5);

    // Aliasing: 0x200 shares index 0 with 0x100 and replaces it.
    next_cycle();
    drive(1'b1, 32'h200, 1'b1, 32'h40);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    pc_if = 32'h100;
    @(negedge clk);
    check("alias_old_hit", 64'(pred_hit), 64'd0);
    next_cycle();
    pc_if = 32'h200;
    @(negedge clk);
    check("alias_new_hit", 64'(pred_hit), 64'd1);
    check("alias_new_target", 64'(pred_target), 64'h40);
    check("alias_cnt", 64'(mispredict_cnt), 64'd6);

    // Lookup and allocate of 0x104 in the same cycle.
    next_cycle();
    drive(1'b1, 32'h104, 1'b1, 32'h1234);
    pc_if = 32'h104;
    @(negedge clk);
    check("rw_same_hit", 64'(pred_hit), 64'd0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check("rw_next_hit", 64'(pred_hit), 64'd1);
    check("rw_next_target", 64'(pred_target), 64'h1234);

    // Four back-to-back taken updates reach strong-T, so one NT still
    // predicts taken.
    next_cycle();
    pc_if = 32'h108;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h108, 1'b1, 32'h700);
      next_cycle();
    end
    drive(1'b1, 32'h108, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check("b2b_taken", 64'(pred_taken), 64'd1);
    check("b2b_cnt", 64'(mispredict_cnt), 64'd9);

    // Reset asserted while an update is pending: the update is discarded.
    next_cycle();
    drive(1'b1, 32'h300, 1'b1, 32'h55);
    pc_if = 32'h300;
    #2 rst_n = 1'b0;
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check("midreset_cnt", 64'(mispredict_cnt), 64'd0);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("midreset_hit", 64'(pred_hit), 64'd0);
    check("midreset_cnt_after", 64'(mispredict_cnt), 64'd0);
`else
    // With history: a taken update at ghr=0 moves ghr to 1, so 0x100 now
    // indexes entry 1 and misses.
    drive(1'b1, 32'h100, 1'b1, 32'h80);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    pc_if = 32'h100;
    @(negedge clk);
    check("gshare_hit", 64'(pred_hit), 64'd0);
    check("gshare_cnt", 64'(mispredict_cnt), 64'd1);
`endif

    // Randomized phase. A small PC pool forces hits, aliasing and
    // back-to-back updates of the same entry.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      drive(1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)), $urandom);
      pc_if = ($urandom_range(0, 3) == 0) ? upd_pc : rand_pc();
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
